instr_fetch: RTL and testbench

Instruction fetch sequencer that produces the 16-bit instruction word and one-cycle load strobe consumed by the instruction register. It holds the program counter and fetches from instruction memory over a req/ack handshake. It presents the word with a load pulse, then waits for the execute stage to finish before fetching the next instruction or taking a branch target.

---
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory over
// req/ack, presents each word with a one-cycle IR load strobe, then waits for execute.
module instr_fetch #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_data,
    output logic [15:0]   ir_d,
    output logic          en_ir,
    output logic [AW-1:0] pc,
    input  logic          exec_done,
    input  logic          br_take,
    input  logic [AW-1:0] br_target,
    output logic          halt,
    output logic          busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_WAIT_EXEC = 3'd3;
    localparam logic [2:0] S_HALTED    = 3'd4;

    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [AW-1:0] pc_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pc_nxt    = pc + 1'b1;
                state_nxt = (ir_d[15:12] == OP_HALT) ? S_HALTED : S_WAIT_EXEC;
            end
            S_WAIT_EXEC: begin
                if (exec_done) begin
                    state_nxt = S_REQ;
                    if (br_take) pc_nxt = br_target;
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir_d  <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_REQ && imem_ack) ir_d <= imem_data;
        end
    end

    // Outputs decode straight from registered state: no input reaches an output combinationally.
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign en_ir     = (state == S_LOAD);
    assign halt      = (state == S_HALTED);
    assign busy      = (state == S_REQ) || (state == S_LOAD) || (state == S_WAIT_EXEC);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboarded fetches, branching, halt,
// reset mid-request and PC wrap on a second instance reset to 0xFF.
module tb_instr_fetch;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, imem_ack, exec_done, br_take;
    logic [15:0] imem_data;
    logic [7:0]  br_target;
    logic        imem_req, en_ir, halt, busy;
    logic [7:0]  imem_addr, pc;
    logic [15:0] ir_d;

    logic        w_start, w_ack, w_exec;
    logic [15:0] w_data;
    logic        w_req, w_en_ir, w_halt, w_busy;
    logic [7:0]  w_addr, w_pc;
    logic [15:0] w_ir_d;

    int     checks   = 0;
    int     failures = 0;
    fetch_t sb[$];
    logic   prev_en_ir = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir_d(ir_d), .en_ir(en_ir), .pc(pc),
        .exec_done(exec_done), .br_take(br_take), .br_target(br_target),
        .halt(halt), .busy(busy)
    );

    instr_fetch #(.AW(8), .RESET_PC(8'hFF)) u_wrap (
        .clk(clk), .rst(rst), .start(w_start),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
        .ir_d(w_ir_d), .en_ir(w_en_ir), .pc(w_pc),
        .exec_done(w_exec), .br_take(1'b0), .br_target(8'h00),
        .halt(w_halt), .busy(w_busy)
    );

    // Scoreboard: every load strobe must match the oldest acknowledged fetch.
    always @(negedge clk) begin
        fetch_t e;
        if (en_ir) begin
            checks++;
            if (prev_en_ir) begin
                failures++;
                $display("FAIL en_ir_b2b: en_ir high two cycles running, required single pulse");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: en_ir with pc=%h ir_d=%h, no fetch expected", pc, ir_d);
            end else begin
                e = sb.pop_front();
                if (pc !== e.addr || ir_d !== e.data) begin
                    failures++;
                    $display("FAIL sb_load: pc=%h ir_d=%h, required pc=%h ir_d=%h",
                             pc, ir_d, e.addr, e.data);
                end
            end
        end
        prev_en_ir <= en_ir;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Entered at a negedge in REQ; leaves at the negedge after LOAD.
    task automatic do_fetch(input logic [7:0] addr, input logic [15:0] data, input int waits);
        fetch_t e;
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req", {15'd0, imem_req}, 16'd1);
            chk("fetch_addr", {8'd0, imem_addr}, {8'd0, addr});
            if (i == waits) begin
                imem_ack  = 1'b1;
                imem_data = data;
                e.addr    = addr;
                e.data    = data;
                sb.push_back(e);
            end
            step();
        end
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        chk("load_en_ir", {15'd0, en_ir}, 16'd1);
        chk("load_req_low", {15'd0, imem_req}, 16'd0);
        step();
        chk("post_load_en_ir", {15'd0, en_ir}, 16'd0);
        chk("post_load_ir_d", ir_d, data);
    endtask

    // Entered at a negedge in WAIT_EXEC; leaves at the negedge of the first REQ cycle.
    task automatic do_exec(input int delay, input logic br, input logic [7:0] tgt, input logic [7:0] exp_addr);
        for (int i = 0; i < delay; i++) begin
            chk("wait_no_req", {15'd0, imem_req}, 16'd0);
            chk("wait_busy", {15'd0, busy}, 16'd1);
            step();
        end
        exec_done = 1'b1;
        br_take   = br;
        br_target = tgt;
        step();
        exec_done = 1'b0;
        br_take   = 1'b0;
        br_target = 8'h00;
        chk("exec_req", {15'd0, imem_req}, 16'd1);
        chk("exec_addr", {8'd0, imem_addr}, {8'd0, exp_addr});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; imem_ack = 0; imem_data = 16'h0; exec_done = 0; br_take = 0; br_target = 8'h0;
        w_start = 0; w_ack = 0; w_data = 16'h0; w_exec = 0;
        step();
        chk("rst_pc", {8'd0, pc}, 16'h0000);
        chk("rst_addr", {8'd0, imem_addr}, 16'h0000);
        chk("rst_ir_d", ir_d, 16'h0000);
        chk("rst_outs", {12'd0, imem_req, en_ir, halt, busy}, 16'h0000);
        rst = 1'b0;
        step();
        step();
        chk("idle_no_req", {15'd0, imem_req}, 16'd0);
        chk("idle_busy", {15'd0, busy}, 16'd0);
    endtask

    task automatic test_wait_fetch();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {15'd0, busy}, 16'd1);
        do_fetch(8'h00, 16'h1234, 2);
        chk("wait_fetch_pc", {8'd0, pc}, 16'h0001);
        chk("wait_fetch_busy", {15'd0, busy}, 16'd1);
    endtask

    task automatic test_sequential();
        // Stray acks in WAIT_EXEC must not trigger a fetch or load.
        imem_ack  = 1'b1;
        imem_data = 16'hBAD0;
        step();
        step();
        imem_ack = 1'b0;
        chk("stray_ack_en_ir", {15'd0, en_ir}, 16'd0);
        chk("stray_ack_req", {15'd0, imem_req}, 16'd0);
        do_exec(1, 1'b0, 8'h00, 8'h01);
        do_fetch(8'h01, 16'h1111, 0);
        do_exec(3, 1'b0, 8'h00, 8'h02);
        do_fetch(8'h02, 16'h2222, 0);
        chk("seq_pc", {8'd0, pc}, 16'h0003);
    endtask

    task automatic test_branch();
        // br_take without exec_done is ignored.
        br_take   = 1'b1;
        br_target = 8'h77;
        step();
        br_take = 1'b0;
        chk("br_no_exec_pc", {8'd0, pc}, 16'h0003);
        do_exec(0, 1'b1, 8'h40, 8'h40);
        do_fetch(8'h40, 16'h5A5A, 1);
        chk("br_pc", {8'd0, pc}, 16'h0041);
        do_exec(2, 1'b0, 8'h99, 8'h41);
        do_fetch(8'h41, 16'h0F0F, 0);
    endtask

    task automatic test_reset_mid();
        do_exec(0, 1'b0, 8'h00, 8'h42);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_pc", {8'd0, pc}, 16'h0000);
        chk("mid_rst_ir_d", ir_d, 16'h0000);
        step();
        rst = 1'b0;
        step();
        step();
        chk("mid_rst_idle", {14'd0, imem_req, en_ir}, 16'd0);
    endtask

    task automatic test_halt();
        start = 1'b1;
        step();
        start = 1'b0;
        do_fetch(8'h00, 16'hF000, 0);
        chk("halt_set", {15'd0, halt}, 16'd1);
        chk("halt_busy", {15'd0, busy}, 16'd0);
        start = 1'b1; exec_done = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_no_req", {14'd0, imem_req, en_ir}, 16'd0);
            chk("halt_sticky", {15'd0, halt}, 16'd1);
        end
        start = 1'b0; exec_done = 1'b0; imem_ack = 1'b0;
        chk("halt_pc", {8'd0, pc}, 16'h0001);
        #2 rst = 1'b1;
        #1 chk("halt_cleared", {15'd0, halt}, 16'd0);
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        chk("wrap_rst_pc", {8'd0, w_pc}, 16'h00FF);
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk("wrap_req", {15'd0, w_req}, 16'd1);
        chk("wrap_addr", {8'd0, w_addr}, 16'h00FF);
        w_ack  = 1'b1;
        w_data = 16'h0ABC;
        step();
        w_ack = 1'b0;
        chk("wrap_en_ir", {15'd0, w_en_ir}, 16'd1);
        chk("wrap_ir_d", w_ir_d, 16'h0ABC);
        step();
        chk("wrap_pc", {8'd0, w_pc}, 16'h0000);
        w_exec = 1'b1;
        step();
        w_exec = 1'b0;
        chk("wrap_next_req", {15'd0, w_req}, 16'd1);
        chk("wrap_next_addr", {8'd0, w_addr}, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_wait_fetch();
        test_sequential();
        test_branch();
        test_reset_mid();
        test_halt();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d fetches never loaded, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
